// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master round-robin arbiter/sequencer in front of a dual_ram word store
// Ports:
//   clk, rst (async, active low)
//   mN_req_valid/ready/we/addr/wdata : command handshake per master (N=0,1), ready is the combinational grant
//   mN_rsp_valid/rdata/err           : one-cycle response, one cycle after accept
//   ram_wen/w_addr/w_data            : RAM write port, driven combinationally by the granted write
//   ram_ren/r_addr, ram_r_data       : RAM read port, data returns one cycle after ram_ren
// Build option: define ARB_RANGE_CHECK_EN to answer addresses past MEM_NUM-4 with rsp_err instead of using the RAM.
module ram_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 7,
  parameter int MEM_NUM = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic            m0_req_we,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic [4*DW-1:0] m0_req_wdata,
  output logic            m0_rsp_valid,
  output logic [4*DW-1:0] m0_rsp_rdata,
  output logic            m0_rsp_err,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic            m1_req_we,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [4*DW-1:0] m1_req_wdata,
  output logic            m1_rsp_valid,
  output logic [4*DW-1:0] m1_rsp_rdata,
  output logic            m1_rsp_err,
  output logic            ram_wen,
  output logic [AW-1:0]   ram_w_addr,
  output logic [4*DW-1:0] ram_w_data,
  output logic            ram_ren,
  output logic [AW-1:0]   ram_r_addr,
  input  logic [4*DW-1:0] ram_r_data
);
`ifdef ARB_RANGE_CHECK_EN
  localparam bit chk = 1'b1;
`else
  localparam bit chk = 1'b0;
`endif
  localparam logic [AW:0] three = (AW+1)'(3);
  logic v0, v1, in0, in1, diff, ovl, g0, g1, wr0, wr1, rd0, rd1, rr;
  logic [1:0] pend_rd, pend_wr, pend_err;
  logic [AW:0] a0x, a1x;
  // requests are masked while reset is held so nothing is granted or driven
  assign v0 = m0_req_valid & rst;
  assign v1 = m1_req_valid & rst;
  assign in0 = !chk || 32'(m0_req_addr) <= MEM_NUM - 4;
  assign in1 = !chk || 32'(m1_req_addr) <= MEM_NUM - 4;
  assign a0x = {1'b0, m0_req_addr};
  assign a1x = {1'b0, m1_req_addr};
  assign diff = m0_req_we ^ m1_req_we;
  // partial overlap: word ranges intersect but addresses differ, RAM cannot forward it
  assign ovl = (m0_req_addr != m1_req_addr) && (a0x + three >= a1x) && (a1x + three >= a0x);
  // mixed read/write: both go unless partially overlapping, then the write wins
  assign g0 = v0 & (~v1 | (diff ? (~ovl | m0_req_we) : ~rr));
  assign g1 = v1 & (~v0 | (diff ? (~ovl | m1_req_we) : rr));
  assign m0_req_ready = g0;
  assign m1_req_ready = g1;
  assign wr0 = g0 & m0_req_we & in0;
  assign wr1 = g1 & m1_req_we & in1;
  assign rd0 = g0 & ~m0_req_we & in0;
  assign rd1 = g1 & ~m1_req_we & in1;
  assign ram_wen = wr0 | wr1;
  assign ram_w_addr = wr0 ? m0_req_addr : wr1 ? m1_req_addr : '0;
  assign ram_w_data = wr0 ? m0_req_wdata : wr1 ? m1_req_wdata : '0;
  assign ram_ren = rd0 | rd1;
  assign ram_r_addr = rd0 ? m0_req_addr : rd1 ? m1_req_addr : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= 1'b0;
      pend_rd <= '0;
      pend_wr <= '0;
      pend_err <= '0;
    end else begin
      if (v0 & v1 & ~diff) rr <= ~rr;
      pend_rd <= {rd1, rd0};
      pend_wr <= {wr1, wr0};
      pend_err <= {g1 & ~in1, g0 & ~in0};
    end
  end
  assign m0_rsp_valid = pend_rd[0] | pend_wr[0] | pend_err[0];
  assign m1_rsp_valid = pend_rd[1] | pend_wr[1] | pend_err[1];
  assign m0_rsp_rdata = pend_rd[0] ? ram_r_data : '0;
  assign m1_rsp_rdata = pend_rd[1] ? ram_r_data : '0;
  assign m0_rsp_err = pend_err[0];
  assign m1_rsp_err = pend_err[1];
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer in front of the `dual_ram` word store (one write port, one read port, 4-byte little-endian words, 1-cycle read latency, exact-address read/write forwarding). It accepts read/write commands from two masters (m0, m1) over valid/ready handshakes. It grants the RAM ports round-robin on contention, and issues a read and a write in the same cycle when they come from different masters and do not partially overlap. It returns one response per accepted command to the issuing master.

## Interface
- `DW`, 8, byte width; word = 4*DW
- `AW`, 7, byte-address width
- `MEM_NUM`, 128, bytes in the RAM

- `clk` in 1 — clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `mN_req_valid` (N=0,1) in 1 — command valid; held stable until accepted
- `mN_req_ready` out 1 — command accepted this cycle (combinational grant)
- `mN_req_we` in 1 — 1 write, 0 read
- `mN_req_addr` in AW — byte address of word LSB
- `mN_req_wdata` in 4*DW — write data
- `mN_rsp_valid` out 1 — one-cycle response pulse
- `mN_rsp_rdata` out 4*DW — read data; 0 unless read response
- `mN_rsp_err` out 1 — address out of range (qualified by rsp_valid)
- `ram_wen`, `ram_w_addr`[AW], `ram_w_data`[4*DW] out — RAM write port
- `ram_ren`, `ram_r_addr`[AW] out — RAM read port
- `ram_r_data` in 4*DW — RAM read data, valid the cycle after `ram_ren`

## Operation
- State: round-robin pointer `rr` (1 bit, which master wins next contention), response tracking regs per master: `pend_rd`, `pend_wr`, `pend_err`.
- Reset (`rst` low, async): `rr`=0 (m0 priority), all pend regs 0; all `mN_rsp_valid`/`mN_rsp_err`=0, `mN_rsp_rdata`=0; `mN_req_ready`, `ram_wen`, `ram_ren` forced 0.
- Range check: command in range iff addr <= MEM_NUM-4. Out-of-range command is accepted (ready=1 when granted), never drives RAM, and is answered with err=1.
- Grant rules per cycle:
  - Only one master valid: granted.
  - Both valid, one read and one write: both granted, unless byte ranges [addr, addr+3] overlap with addr_r != addr_w. In that case only the write is granted; the read waits (no rr update).
  - Both valid, same type: master `rr` granted; `rr` toggles to the loser.
  - Non-contended grant leaves `rr` unchanged.
- Grants drive RAM combinationally: granted in-range write → `ram_wen`=1 with its addr/data; granted in-range read → `ram_ren`=1 with its addr. Ungranted port: enable 0, addr/data 0.
- Response: master accepted at edge E gets `rsp_valid`=1 for the cycle after E. Read: `rsp_rdata`=`ram_r_data`. Write: rdata 0, err 0. Out-of-range: rdata 0, err 1.
- Exact-address same-cycle read+write: read returns the newly written word via RAM forwarding.
- A master may issue back-to-back commands (one per cycle); responses return in order, one per cycle.

## Timing
- Request→RAM enable: 0 cycles (combinational from valid + grant state).
- Request accept→response: 1 cycle, fixed; no backpressure on responses.
- Loser of contention waits ≥1 cycle; with continuous contention each master wins every other cycle (no starvation).
- Deferred overlapping read is granted the first cycle without the overlapping write.
- Reset asserted mid-transaction: pending responses dropped, no rsp_valid after reset release until a new accept.

## Configuration
- `ARB_RANGE_CHECK_EN` defined: range check as above; `rsp_err` can assert.
- Not defined: no range check, all commands forwarded to RAM (address wrap is the RAM's behaviour), `mN_rsp_err` tied 0.

## Test plan
- Reset/idle: hold `rst`=0 with both valids high → ready=0, wen=ren=0, all rsp outputs 0; after release `rr`=0.
- Write/readback: m0 writes 0xDEADBEEF @0x10, next cycle m1 reads @0x10 → m1 rsp_valid 1 cycle later, rdata 0xDEADBEEF.
- Contention: both read continuously for 4 cycles → grants m0,m1,m0,m1; responses interleave, one per cycle.
- Parallel: m0 writes 0x11223344 @0x20, m1 reads @0x20 same cycle → both ready; m1 rdata 0x11223344. Repeat with m1 read @0x22 → only m0 ready; m1 granted next cycle, rdata reflects the new bytes.
- Range (macro defined): m0 read @0x7D → ready=1, ram_ren=0, next cycle rsp_valid=1, err=1, rdata 0. Without macro: ram_ren=1, err=0.
- Async reset mid-flight: assert `rst` low half a cycle after a read accept → no rsp_valid is produced for it.
